// File: rtl/cache_types_pkg.sv
// Shared types and constants for the cache-to-memory line/burst adaptor.
package cache_types_pkg;

    localparam int LINE_BITS = 256;
    localparam int BEAT_BITS = 64;
    localparam int NUM_BEATS = LINE_BITS / BEAT_BITS;

    typedef logic [LINE_BITS-1:0] line_t;
    typedef logic [BEAT_BITS-1:0] beat_t;
    typedef logic [1:0]           beat_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } adaptor_state_t;

    localparam beat_idx_t LAST_BEAT = beat_idx_t'(NUM_BEATS - 1);

    // Beat k of a line occupies bits [64k+63:64k].
    function automatic beat_t get_beat(input line_t line, input beat_idx_t k);
        return line[{k, 6'b0} +: BEAT_BITS];
    endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts a 256-bit cache line fill/writeback into a 4-beat 64-bit memory burst.
// Optional CACHELINE_CRITICAL_WORD_FIRST_EN starts read bursts at the requested beat.
module cacheline_adaptor
    import cache_types_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  line_t       line_i,
    output line_t       line_o,
    input  logic [31:0] address_i,
    input  logic        read_i,
    input  logic        write_i,
    output logic        resp_o,
    input  beat_t       burst_i,
    output beat_t       burst_o,
    output logic [31:0] address_o,
    output logic        read_o,
    output logic        write_o,
    input  logic        resp_i
);

    adaptor_state_t state_q;
    beat_idx_t      cnt_q;
    beat_idx_t      start_q;
    line_t          rline_q;
    line_t          wline_q;
    beat_t          burst_q;
    logic [31:0]    addr_q;
    logic           read_q;
    logic           write_q;
    logic           resp_q;

    beat_idx_t      cnt_d;
    beat_idx_t      slot;
    beat_idx_t      read_start;
    logic [31:0]    read_addr;
    logic           unused_addr_bits;

`ifdef CACHELINE_CRITICAL_WORD_FIRST_EN
    assign read_start       = address_i[4:3];
    assign read_addr        = {address_i[31:3], 3'b0};
    assign unused_addr_bits = ^address_i[2:0];
`else
    assign read_start       = '0;
    assign read_addr        = {address_i[31:5], 5'b0};
    assign unused_addr_bits = ^address_i[4:0];
`endif

    assign cnt_d = cnt_q + 2'd1;
    // 2-bit add wraps slot 3 -> 0 for critical-word-first ordering.
    assign slot  = cnt_q + start_q;

    // NOTE: state is updated only with non-blocking assignments so every branch
    // sees the values from before this edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the fill line register is reset too: a burst interrupted by
            // reset must not leave a partial line visible on line_o.
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= '0;
            rline_q <= '0;
            wline_q <= '0;
            burst_q <= '0;
            addr_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (write_i) begin
                        wline_q <= line_i;
                        addr_q  <= {address_i[31:5], 5'b0};
                        burst_q <= get_beat(line_i, 2'd0);
                        write_q <= 1'b1;
                        state_q <= WRITE;
                    end else if (read_i) begin
                        addr_q  <= read_addr;
                        start_q <= read_start;
                        read_q  <= 1'b1;
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        rline_q[{slot, 6'b0} +: BEAT_BITS] <= burst_i;
                        if (cnt_q == LAST_BEAT) begin
                            read_q  <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        if (cnt_q == LAST_BEAT) begin
                            write_q <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            cnt_q   <= cnt_d;
                            burst_q <= get_beat(wline_q, cnt_d);
                        end
                    end
                end
                DONE: begin
                    resp_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign line_o    = rline_q;
    assign burst_o   = burst_q;
    assign address_o = addr_q;
    assign read_o    = read_q;
    assign write_o   = write_q;
    assign resp_o    = resp_q;

endmodule
